// File: rtl/hazard_pkg.sv
// Shared types and encodings for the MIPS32 five-stage hazard controller.
package hazard_pkg;

    localparam int SB_AW  = 5;
    localparam int FWD_SW = 2;

    localparam logic [FWD_SW-1:0] FWD_RF    = 2'b00;
    localparam logic [FWD_SW-1:0] FWD_EXMEM = 2'b01;
    localparam logic [FWD_SW-1:0] FWD_MEMWB = 2'b10;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        FREEZE   = 2'b10
    } hz_state_e;

    typedef struct packed {
        logic             valid;
        logic             reg_write;
        logic             mem_read;
        logic [SB_AW-1:0] waddr;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '0;

    // Control bits of an invalid instruction are squashed so a bubble never matches.
    function automatic sb_entry_t make_entry(
        input logic             valid,
        input logic             reg_write,
        input logic             mem_read,
        input logic [SB_AW-1:0] waddr
    );
        sb_entry_t e;
        e.valid     = valid;
        e.reg_write = reg_write & valid;
        e.mem_read  = mem_read & valid;
        e.waddr     = waddr;
        return e;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one source register against one scoreboard entry; $0 never matches.
module hazard_match
    import hazard_pkg::*;
(
    input  logic [SB_AW-1:0] src,
    input  logic             src_used,
    input  sb_entry_t        entry,
    output logic             hit
);

    assign hit = src_used && entry.valid && entry.reg_write &&
                 (entry.waddr == src) && (src != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the five-stage MIPS32 pipe: stalls, flushes, forwarding.
// Optional build macro HAZ_PERF_CNT_EN adds saturating stall/flush/freeze counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW = SB_AW,
    parameter int FWD_W  = FWD_SW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic [REG_AW-1:0] id_waddr,
    input  logic              ex_redirect,
    input  logic              mem_stall,
    output logic              pc_write_en,
    output logic              ifid_write_en,
    output logic              ifid_flush,
    output logic              idex_write_en,
    output logic              idex_bubble,
    output logic              exmem_write_en,
    output logic [FWD_W-1:0]  fwd_a,
    output logic [FWD_W-1:0]  fwd_b,
    output logic              id_byp_a,
    output logic              id_byp_b,
    output logic [1:0]        state
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt,
    output logic [31:0]       freeze_cnt
`endif
);

    sb_entry_t sb_ex, sb_mem, sb_wb;
    sb_entry_t id_entry;

    logic rs_ex, rs_mem, rs_wb;
    logic rt_ex, rt_mem, rt_wb;

    logic frz, redirect, load_use, squash;
    hz_state_e st;

    logic [FWD_W-1:0] fwd_a_nxt, fwd_b_nxt;

    assign id_entry = make_entry(id_valid, id_reg_write, id_mem_read, id_waddr);

    hazard_match u_rs_ex  (.src(id_rs), .src_used(id_uses_rs), .entry(sb_ex),  .hit(rs_ex));
    hazard_match u_rs_mem (.src(id_rs), .src_used(id_uses_rs), .entry(sb_mem), .hit(rs_mem));
    hazard_match u_rs_wb  (.src(id_rs), .src_used(id_uses_rs), .entry(sb_wb),  .hit(rs_wb));
    hazard_match u_rt_ex  (.src(id_rt), .src_used(id_uses_rt), .entry(sb_ex),  .hit(rt_ex));
    hazard_match u_rt_mem (.src(id_rt), .src_used(id_uses_rt), .entry(sb_mem), .hit(rt_mem));
    hazard_match u_rt_wb  (.src(id_rt), .src_used(id_uses_rt), .entry(sb_wb),  .hit(rt_wb));

    // Priority: freeze > redirect > load-use > run.
    assign frz      = mem_stall;
    assign redirect = !frz && ex_redirect;
    assign load_use = !frz && !redirect && id_valid && sb_ex.mem_read && (rs_ex || rt_ex);
    assign squash   = redirect || load_use;

    // state is a classification of the current cycle, so it is coincident with the enables.
    always_comb begin
        pc_write_en    = 1'b1;
        ifid_write_en  = 1'b1;
        ifid_flush     = 1'b0;
        idex_write_en  = 1'b1;
        idex_bubble    = 1'b0;
        exmem_write_en = 1'b1;
        st             = RUN;
        if (frz) begin
            pc_write_en    = 1'b0;
            ifid_write_en  = 1'b0;
            idex_write_en  = 1'b0;
            exmem_write_en = 1'b0;
            st             = FREEZE;
        end else if (redirect) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_bubble   = 1'b1;
            st            = LU_STALL;
        end
    end

    assign state = st;

    // A WB producer only needs the bypass when no younger producer shadows it.
    assign id_byp_a = rs_wb && !rs_ex && !rs_mem;
    assign id_byp_b = rt_wb && !rt_ex && !rt_mem;

    always_comb begin
        fwd_a_nxt = FWD_RF;
        fwd_b_nxt = FWD_RF;
        if (!squash) begin
            if (rs_ex)       fwd_a_nxt = FWD_EXMEM;
            else if (rs_mem) fwd_a_nxt = FWD_MEMWB;
            if (rt_ex)       fwd_b_nxt = FWD_EXMEM;
            else if (rt_mem) fwd_b_nxt = FWD_MEMWB;
        end
    end

    // ---- ID -> EX / EX -> MEM / MEM -> WB scoreboard boundary ----
    always_ff @(posedge clk) begin
        if (reset) begin
            sb_ex  <= SB_BUBBLE;
            sb_mem <= SB_BUBBLE;
            sb_wb  <= SB_BUBBLE;
            fwd_a  <= FWD_RF;
            fwd_b  <= FWD_RF;
        end else if (!frz) begin
            sb_wb  <= sb_mem;
            sb_mem <= sb_ex;
            sb_ex  <= squash ? SB_BUBBLE : id_entry;
            fwd_a  <= fwd_a_nxt;
            fwd_b  <= fwd_b_nxt;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            freeze_cnt <= '0;
        end else begin
            if (load_use) stall_cnt  <= sat_inc(stall_cnt);
            if (redirect) flush_cnt  <= sat_inc(flush_cnt);
            if (frz)      freeze_cnt <= sat_inc(freeze_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios plus randomized traffic vs. a reference model.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_waddr;
    logic       id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
    logic       ex_redirect, mem_stall;
    logic       pc_write_en, ifid_write_en, ifid_flush, idex_write_en, idex_bubble, exmem_write_en;
    logic [1:0] fwd_a, fwd_b;
    logic       id_byp_a, id_byp_b;
    logic [1:0] state;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: in-flight instructions by age (0 = EX, 1 = MEM, 2 = WB).
    logic       m_v[3], m_rw[3], m_mr[3];
    logic [4:0] m_wa[3];
    logic [1:0] m_fa, m_fb;
    logic       n_v[3], n_rw[3], n_mr[3];
    logic [4:0] n_wa[3];
    logic [1:0] n_fa, n_fb;

    hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_waddr(id_waddr),
        .ex_redirect(ex_redirect), .mem_stall(mem_stall),
        .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en), .ifid_flush(ifid_flush),
        .idex_write_en(idex_write_en), .idex_bubble(idex_bubble), .exmem_write_en(exmem_write_en),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .id_byp_a(id_byp_a), .id_byp_b(id_byp_b),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Age of the youngest in-flight writer of src, or 3 if none.
    function automatic int nearest(input logic [4:0] src, input logic used);
        if (!used || src == 5'd0) return 3;
        for (int k = 0; k < 3; k++)
            if (m_v[k] && m_rw[k] && m_wa[k] == src) return k;
        return 3;
    endfunction

    function automatic logic [1:0] fwd_code(input int age);
        return (age == 0) ? 2'b01 : (age == 1) ? 2'b10 : 2'b00;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 3; k++) begin
            m_v[k] = 0; m_rw[k] = 0; m_mr[k] = 0; m_wa[k] = '0;
        end
        m_fa = 2'b00; m_fb = 2'b00;
    endtask

    task automatic drive(input logic v, input int rs, input int rt, input logic urs, input logic urt,
                         input logic rw, input logic mr, input int wa,
                         input logic red, input logic stl, input logic rst);
        id_valid = v; id_rs = rs[4:0]; id_rt = rt[4:0];
        id_uses_rs = urs; id_uses_rt = urt;
        id_reg_write = rw; id_mem_read = mr; id_waddr = wa[4:0];
        ex_redirect = red; mem_stall = stl; reset = rst;
    endtask

    // Check every output against the model mid-cycle and compute the model's next state.
    task automatic settle();
        int na, nb;
        logic frz, red, lu, sq;
        @(negedge clk);
        na  = nearest(id_rs, id_uses_rs);
        nb  = nearest(id_rt, id_uses_rt);
        frz = mem_stall;
        red = !frz && ex_redirect;
        lu  = !frz && !red && id_valid && m_mr[0] && (na == 0 || nb == 0);
        sq  = red || lu;
        check("pc_write_en",    32'(pc_write_en),    32'(!frz && !lu));
        check("ifid_write_en",  32'(ifid_write_en),  32'(!frz && !lu));
        check("ifid_flush",     32'(ifid_flush),     32'(red));
        check("idex_write_en",  32'(idex_write_en),  32'(!frz));
        check("idex_bubble",    32'(idex_bubble),    32'(sq));
        check("exmem_write_en", 32'(exmem_write_en), 32'(!frz));
        check("fwd_a",          32'(fwd_a),          32'(m_fa));
        check("fwd_b",          32'(fwd_b),          32'(m_fb));
        check("id_byp_a",       32'(id_byp_a),       32'(na == 2));
        check("id_byp_b",       32'(id_byp_b),       32'(nb == 2));
        check("state",          32'(state),          frz ? 32'd2 : lu ? 32'd1 : 32'd0);
        n_v = m_v; n_rw = m_rw; n_mr = m_mr; n_wa = m_wa; n_fa = m_fa; n_fb = m_fb;
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                n_v[k] = 0; n_rw[k] = 0; n_mr[k] = 0; n_wa[k] = '0;
            end
            n_fa = 2'b00; n_fb = 2'b00;
        end else if (!frz) begin
            for (int k = 2; k > 0; k--) begin
                n_v[k] = m_v[k-1]; n_rw[k] = m_rw[k-1]; n_mr[k] = m_mr[k-1]; n_wa[k] = m_wa[k-1];
            end
            if (sq) begin
                n_v[0] = 0; n_rw[0] = 0; n_mr[0] = 0; n_wa[0] = '0;
            end else begin
                n_v[0] = id_valid; n_rw[0] = id_reg_write && id_valid;
                n_mr[0] = id_mem_read && id_valid; n_wa[0] = id_waddr;
            end
            n_fa = sq ? 2'b00 : fwd_code(na);
            n_fb = sq ? 2'b00 : fwd_code(nb);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_v = n_v; m_rw = n_rw; m_mr = n_mr; m_wa = n_wa; m_fa = n_fa; m_fb = n_fb;
        #1;
    endtask

    task automatic nop_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            settle(); tick();
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (2) @(posedge clk);
        clear_model();
        #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        check("rst_fwd_a", 32'(fwd_a), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_pc_we", 32'(pc_write_en), 32'd1);
        tick();

        // lw $8 ; add $9,$8,$2 -> one stall, then fwd_a from MEM/WB
        drive(1, 29, 8, 1, 0, 1, 1, 8, 0, 0, 0); settle(); tick();
        drive(1, 8, 2, 1, 1, 1, 0, 9, 0, 0, 0); settle();
        check("lu_pc_we",   32'(pc_write_en),   32'd0);
        check("lu_ifid_we", 32'(ifid_write_en), 32'd0);
        check("lu_bubble",  32'(idex_bubble),   32'd1);
        check("lu_state",   32'(state),         32'd1);
        tick();
        settle();
        check("lu_once", 32'(state), 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); settle();
        check("lu_fwd_a", 32'(fwd_a), 32'd2);
        tick();
        nop_cycles(3);

        // add $8 ; sub $9,$8,$8 -> both operands from EX/MEM
        drive(1, 1, 2, 1, 1, 1, 0, 8, 0, 0, 0); settle(); tick();
        drive(1, 8, 8, 1, 1, 1, 0, 9, 0, 0, 0); settle();
        check("alu_nostall", 32'(state), 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); settle();
        check("alu_fwd_a", 32'(fwd_a), 32'd1);
        check("alu_fwd_b", 32'(fwd_b), 32'd1);
        tick();
        nop_cycles(3);

        // add $8 ; add $8 ; or $3,$8,$0 -> nearest producer, $0 stays regfile
        drive(1, 1, 2, 1, 1, 1, 0, 8, 0, 0, 0); settle(); tick();
        drive(1, 4, 5, 1, 1, 1, 0, 8, 0, 0, 0); settle(); tick();
        drive(1, 8, 0, 1, 1, 1, 0, 3, 0, 0, 0); settle(); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); settle();
        check("near_fwd_a", 32'(fwd_a), 32'd1);
        check("near_fwd_b", 32'(fwd_b), 32'd0);
        tick();
        nop_cycles(3);

        // writer of $0 then reader of $0
        drive(1, 1, 2, 1, 1, 1, 1, 0, 0, 0, 0); settle(); tick();
        drive(1, 0, 0, 1, 1, 1, 0, 4, 0, 0, 0); settle();
        check("r0_state", 32'(state), 32'd0);
        check("r0_byp_a", 32'(id_byp_a), 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); settle();
        check("r0_fwd_a", 32'(fwd_a), 32'd0);
        tick();
        nop_cycles(3);

        // redirect coincident with load-use
        drive(1, 29, 8, 1, 0, 1, 1, 8, 0, 0, 0); settle(); tick();
        drive(1, 8, 2, 1, 1, 1, 0, 9, 1, 0, 0); settle();
        check("red_flush",  32'(ifid_flush),  32'd1);
        check("red_bubble", 32'(idex_bubble), 32'd1);
        check("red_pc_we",  32'(pc_write_en), 32'd1);
        check("red_state",  32'(state),       32'd0);
        tick();
        nop_cycles(3);

        // freeze for 3 cycles with fwd_a=01 held, then release
        drive(1, 1, 2, 1, 1, 1, 0, 8, 0, 0, 0); settle(); tick();
        drive(1, 8, 2, 1, 0, 1, 0, 9, 0, 0, 0); settle(); tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0); settle();
            check("frz_pc_we",  32'(pc_write_en),    32'd0);
            check("frz_exm_we", 32'(exmem_write_en), 32'd0);
            check("frz_fwd_a",  32'(fwd_a),          32'd1);
            check("frz_state",  32'(state),          32'd2);
            tick();
        end
        drive(1, 8, 0, 1, 0, 1, 0, 10, 0, 0, 0); settle();
        check("rel_fwd_a", 32'(fwd_a), 32'd1);
        tick();
        // freeze again, reset asserted in its second cycle
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); settle();
        check("frz2_fwd_a", 32'(fwd_a), 32'd2);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1); settle(); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); settle();
        check("rstfrz_fwd_a", 32'(fwd_a), 32'd0);
        check("rstfrz_state", 32'(state), 32'd0);
        tick();

        // randomized traffic over a small register window to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, int'($urandom_range(0, 4)),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 59) == 0);
            settle(); tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the five-stage MIPS32 datapath (IF, ID, EX, MEM, WB).
- Tracks destination registers of instructions in flight in EX, MEM and WB with an internal scoreboard.
- Generates per-stage write-enable, bubble and flush controls, covering load-use stall, EX-resolved redirect and data-memory freeze.
- Produces registered forwarding selects aligned to the instruction in EX, plus ID-stage write-back bypass selects.

Parameters:
REG_AW, 5, register address width
FWD_W, 2, forwarding select width

Ports:
clk  in  1  single clock; every register updates on rising edge
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID stage holds a real instruction
id_rs  in  REG_AW  source register 1 of ID instruction
id_rt  in  REG_AW  source register 2 of ID instruction
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_reg_write  in  1  ID instruction writes a register
id_mem_read  in  1  ID instruction is a load
id_waddr  in  REG_AW  ID instruction destination register
ex_redirect  in  1  taken branch or jump resolved in EX
mem_stall  in  1  data memory busy; freeze whole pipe
pc_write_en  out  1  PC register load enable
ifid_write_en  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID loads a NOP
idex_write_en  out  1  ID/EX load enable
idex_bubble  out  1  ID/EX loads zeroed controls
exmem_write_en  out  1  EX/MEM and MEM/WB load enable
fwd_a  out  FWD_W  EX operand A select (registered): 00 regfile, 01 EX/MEM alu_res, 10 MEM/WB write_data
fwd_b  out  FWD_W  EX operand B select (registered), same encoding
id_byp_a  out  1  ID operand A takes WB write_data (combinational)
id_byp_b  out  1  ID operand B takes WB write_data (combinational)
state  out  2  00 RUN, 01 LU_STALL, 10 FREEZE

Behaviour:
- Reset:
  - Scoreboard entries ex/mem/wb are all {valid=0, reg_write=0, mem_read=0, waddr=0}.
  - fwd_a and fwd_b are 00; state is RUN.
  - Combinational outputs settle to no-stall values: all write-enables 1, flush 0, bubble 0, id_byp 0.
- Match rule:
  - A source matches an entry when the source is used, the entry is valid with reg_write=1, waddr equals the source, and the source is not 0.
  - Register 0 never matches.
- Priority per cycle, highest first:
  - FREEZE: mem_stall=1. All write-enables 0, flush 0, bubble 0. Scoreboard and fwd registers hold. state=FREEZE. ex_redirect is ignored while frozen; the EX register holds, so the redirect is seen again on release.
  - Redirect: ex_redirect=1. pc_write_en=1, ifid_flush=1, idex_bubble=1. The incoming EX entry is a bubble and fwd selects load 00.
  - Load-use: id_valid=1, ex entry has mem_read=1, and rs or rt matches ex. pc_write_en=0, ifid_write_en=0, idex_bubble=1. The incoming EX entry is a bubble; state=LU_STALL for exactly that cycle.
  - RUN: all enables 1; the ID entry advances into EX.
- Scoreboard advance (any non-FREEZE cycle): wb<=mem, mem<=ex, ex<=ID entry or bubble.
  - The ID entry is {id_valid, id_reg_write & id_valid, id_mem_read & id_valid, id_waddr}.
- Forwarding (registered on advance, evaluated against entries before the shift):
  - fwd_x = 01 if source matches ex.
  - Otherwise fwd_x = 10 if source matches mem.
  - Otherwise 00.
  - The nearer producer wins.
- After a load-use stall the load sits in MEM, so the consumer enters EX with fwd=10. No second stall is taken.
- id_byp_x is 1 when source matches wb and matches neither ex nor mem, in the same cycle. It covers the regfile write/read race.
- Back-to-back stalls: each cycle re-evaluates independently. LU_STALL never lasts more than 1 cycle per load.
- Reset asserted mid-stall or mid-freeze: the next edge clears all state. Outputs return to RUN values.

Optional Feature:
HAZ_PERF_CNT_EN
- Defined: adds outputs stall_cnt[31:0], flush_cnt[31:0] and freeze_cnt[31:0].
  - Each increments, saturating at all-ones, on cycles in LU_STALL, redirect and FREEZE respectively.
  - All three clear on reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package hazard_pkg holds:
  - constants FWD_RF=00, FWD_EXMEM=01, FWD_MEMWB=10;
  - state encodings RUN, LU_STALL, FREEZE;
  - typedef sb_entry_t {valid, reg_write, mem_read, waddr}.
- One natural sub-module: hazard_match, combinational source-versus-entry compare, instantiated 6 times (rs and rt against ex, mem and wb).

Test Plan:
- lw $8 followed by add $9,$8,$2 -> 1 cycle with pc_write_en=0, ifid_write_en=0, idex_bubble=1, state=01. The add then enters EX with fwd_a=10.
- add $8 followed by sub $9,$8,$8 -> no stall; fwd_a=01 and fwd_b=01 on the next edge.
- add $8, add $8, then or $3,$8,$0 -> fwd_a=01 (nearest producer); fwd_b=00.
- Producer to $0 followed by consumer of $0 -> no stall, fwd=00, id_byp=0.
- ex_redirect=1 coincident with a load-use condition -> ifid_flush=1, idex_bubble=1, pc_write_en=1; state stays RUN.
- mem_stall held 3 cycles during a forwarding case -> all enables 0, fwd held for 3 cycles, then resumes unchanged. Reset asserted in cycle 2 -> everything cleared on the next edge.
